// File: rtl/gau_frame_sequencer.sv
// gau_frame_sequencer
//
// Frame-level controller for the Gaussian filter datapath. A start pulse
// makes it walk a WxH RGB image in raster order. For every output pixel it:
//   - fetches the 3x3 neighbourhood from source memory, tap by tap;
//   - streams each tap to the filter's r/g/b channels;
//   - collects the 24-bit filter result and writes it to destination memory.
// Only one output pixel is in flight at any time.
//
// Build option:
//   GAU_SEQ_EDGE_CLAMP_EN  When defined, out-of-bounds neighbours are clamped
//                          to the image edge and read from memory
//                          (replicate-edge border). When undefined,
//                          out-of-bounds taps push zero with no memory read
//                          (zero-pad border).
//
// Ports:
//   i_clk, i_rst           clock; synchronous active-low reset
//   i_start                start pulse, honoured only while idle
//   i_width, i_height      image size, latched on an accepted start
//   i_src_base, i_dst_base source/destination word base addresses
//   o_busy, o_done         frame in progress / one-cycle completion pulse
//   o_rd_*, i_rd_*         source read port. Data arrives one cycle after
//                          the request is accepted.
//   o_{r,g,b}_*, i_{r,g,b}_busy  filter input channels, {b,g,r} = rd word
//   i_result_*, o_result_busy    filter result channel
//   o_wr_*, i_wr_busy      destination write port
// All handshakes transfer on a cycle with vld=1 and busy=0.

module gau_frame_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [DIM_W-1:0]  i_height,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_vld,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_busy,
  input  logic [23:0]       i_rd_data,
  output logic              o_r_vld,
  output logic              o_g_vld,
  output logic              o_b_vld,
  output logic [7:0]        o_r_data,
  output logic [7:0]        o_g_data,
  output logic [7:0]        o_b_data,
  input  logic              i_r_busy,
  input  logic              i_g_busy,
  input  logic              i_b_busy,
  input  logic              i_result_vld,
  input  logic [23:0]       i_result_data,
  output logic              o_result_busy,
  output logic              o_wr_vld,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  input  logic              i_wr_busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH, RDWAIT, PUSH, WAIT_RES, WRITE, DONE
  } state_t;

  state_t            state_q;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DIM_W-1:0]  x_q, y_q;
  logic [ADDR_W-1:0] row_q;          // y_q * width_q, accumulated per row
  logic [3:0]        tap_q;

  logic              busy_q, done_q;
  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              r_vld_q, g_vld_q, b_vld_q;
  logic [7:0]        r_data_q, g_data_q, b_data_q;
  logic              result_busy_q;
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [23:0]       wr_data_q;

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_rd_vld      = rd_vld_q;
  assign o_rd_addr     = rd_addr_q;
  assign o_r_vld       = r_vld_q;
  assign o_g_vld       = g_vld_q;
  assign o_b_vld       = b_vld_q;
  assign o_r_data      = r_data_q;
  assign o_g_data      = g_data_q;
  assign o_b_data      = b_data_q;
  assign o_result_busy = result_busy_q;
  assign o_wr_vld      = wr_vld_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;

  // Handshake and position helpers
  logic rd_xfer, wr_xfer, tap_done;
  logic x_last, y_last, frame_last, cfg_zero;

  assign rd_xfer    = rd_vld_q & ~i_rd_busy;
  assign wr_xfer    = wr_vld_q & ~i_wr_busy;
  // A channel counts as done once its vld has dropped or it transfers now.
  assign tap_done   = (~r_vld_q | ~i_r_busy) & (~g_vld_q | ~i_g_busy) &
                      (~b_vld_q | ~i_b_busy);
  assign x_last     = (x_q == width_q - DIM_W'(1));
  assign y_last     = (y_q == height_q - DIM_W'(1));
  assign frame_last = x_last & y_last;
  assign cfg_zero   = (i_width == '0) | (i_height == '0);

  // Position of the next tap to launch. From IDLE it is the first tap of the
  // frame using the live config inputs. From PUSH it is the following tap of
  // the same pixel. From WRITE it is tap 0 of the next raster pixel.
  logic [DIM_W-1:0]  cfg_w, cfg_h;
  logic [ADDR_W-1:0] cfg_src;
  logic [3:0]        tap_d;
  logic [DIM_W-1:0]  x_d, y_d;
  logic [ADDR_W-1:0] row_d;

  always_comb begin
    cfg_w   = width_q;
    cfg_h   = height_q;
    cfg_src = src_q;
    tap_d   = tap_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        cfg_w   = i_width;
        cfg_h   = i_height;
        cfg_src = i_src_base;
        tap_d   = '0;
        x_d     = '0;
        y_d     = '0;
        row_d   = '0;
      end
      PUSH: tap_d = tap_q + 4'd1;
      WRITE: begin
        tap_d = '0;
        if (x_last) begin
          x_d   = '0;
          y_d   = y_q + DIM_W'(1);
          row_d = row_q + ADDR_W'(width_q);
        end else begin
          x_d = x_q + DIM_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Tap geometry: dy_sel/dx_sel are the offset +1 (0,1,2).
  logic [1:0]        dy_sel, dx_sel;
  logic              edge_top, edge_bot, edge_l, edge_r, tap_pad;
  logic [ADDR_W-1:0] row_sel, tap_addr;
  logic [DIM_W-1:0]  col_sel;

  always_comb begin
    case (tap_d)
      4'd0, 4'd1, 4'd2: dy_sel = 2'd0;
      4'd3, 4'd4, 4'd5: dy_sel = 2'd1;
      default:          dy_sel = 2'd2;
    endcase
    case (tap_d)
      4'd0, 4'd3, 4'd6: dx_sel = 2'd0;
      4'd1, 4'd4, 4'd7: dx_sel = 2'd1;
      default:          dx_sel = 2'd2;
    endcase

    edge_top = (dy_sel == 2'd0) && (y_d == '0);
    edge_bot = (dy_sel == 2'd2) && (y_d == cfg_h - DIM_W'(1));
    edge_l   = (dx_sel == 2'd0) && (x_d == '0);
    edge_r   = (dx_sel == 2'd2) && (x_d == cfg_w - DIM_W'(1));

    // An off-image neighbour clamps back onto the current row/column, so
    // the clamped coordinate is simply the pixel's own.
    if (edge_top || edge_bot || dy_sel == 2'd1) row_sel = row_d;
    else if (dy_sel == 2'd0)                    row_sel = row_d - ADDR_W'(cfg_w);
    else                                        row_sel = row_d + ADDR_W'(cfg_w);

    if (edge_l || edge_r || dx_sel == 2'd1) col_sel = x_d;
    else if (dx_sel == 2'd0)                col_sel = x_d - DIM_W'(1);
    else                                    col_sel = x_d + DIM_W'(1);

    tap_addr = cfg_src + row_sel + ADDR_W'(col_sel);

`ifdef GAU_SEQ_EDGE_CLAMP_EN
    tap_pad = 1'b0;
`else
    tap_pad = edge_top | edge_bot | edge_l | edge_r;
`endif
  end

  // A new tap is launched on an accepted non-empty start, after every tap
  // but the last, and after every write but the last.
  logic go_tap;
  assign go_tap = ((state_q == IDLE)  && i_start && !cfg_zero) ||
                  ((state_q == PUSH)  && tap_done && (tap_q != 4'd8)) ||
                  ((state_q == WRITE) && wr_xfer && !frame_last);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q       <= IDLE;
      width_q       <= '0;
      height_q      <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      row_q         <= '0;
      tap_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_addr_q     <= '0;
      r_vld_q       <= 1'b0;
      g_vld_q       <= 1'b0;
      b_vld_q       <= 1'b0;
      r_data_q      <= '0;
      g_data_q      <= '0;
      b_data_q      <= '0;
      result_busy_q <= 1'b1;
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            width_q  <= i_width;
            height_q <= i_height;
            src_q    <= i_src_base;
            dst_q    <= i_dst_base;
            busy_q   <= 1'b1;
            if (cfg_zero) state_q <= DONE;
          end
        end
        FETCH: begin
          if (rd_xfer) begin
            rd_vld_q <= 1'b0;
            state_q  <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_data_q <= i_rd_data[7:0];
          g_data_q <= i_rd_data[15:8];
          b_data_q <= i_rd_data[23:16];
          r_vld_q  <= 1'b1;
          g_vld_q  <= 1'b1;
          b_vld_q  <= 1'b1;
          state_q  <= PUSH;
        end
        PUSH: begin
          if (r_vld_q && !i_r_busy) r_vld_q <= 1'b0;
          if (g_vld_q && !i_g_busy) g_vld_q <= 1'b0;
          if (b_vld_q && !i_b_busy) b_vld_q <= 1'b0;
          if (tap_done && tap_q == 4'd8) begin
            state_q       <= WAIT_RES;
            result_busy_q <= 1'b0;
          end
        end
        WAIT_RES: begin
          if (i_result_vld) begin
            result_busy_q <= 1'b1;
            wr_vld_q      <= 1'b1;
            wr_addr_q     <= dst_q + row_q + ADDR_W'(x_q);
            wr_data_q     <= i_result_data;
            state_q       <= WRITE;
          end
        end
        WRITE: begin
          if (wr_xfer) begin
            wr_vld_q <= 1'b0;
            if (frame_last) state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Later assignments here override the per-state defaults above.
      if (go_tap) begin
        tap_q <= tap_d;
        x_q   <= x_d;
        y_q   <= y_d;
        row_q <= row_d;
        if (tap_pad) begin
          state_q  <= PUSH;
          r_vld_q  <= 1'b1;
          g_vld_q  <= 1'b1;
          b_vld_q  <= 1'b1;
          r_data_q <= '0;
          g_data_q <= '0;
          b_data_q <= '0;
        end else begin
          state_q   <= FETCH;
          rd_vld_q  <= 1'b1;
          rd_addr_q <= tap_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_gau_frame_sequencer.sv
// Testbench for gau_frame_sequencer. Stimulus queues the expected reads,
// channel taps and writes. Negedge monitors pop and compare them on every
// DUT transfer. Memory and filter are behavioural models.
`timescale 1ns/1ps
module tb_gau_frame_sequencer;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0, start = 1'b0;
  logic [DIM_W-1:0]  width = '0, height = '0;
  logic [ADDR_W-1:0] src_base = '0, dst_base = '0;
  logic              busy, done;
  logic              rd_vld, rd_busy = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data = '0;
  logic              r_vld, g_vld, b_vld;
  logic [7:0]        r_data, g_data, b_data;
  logic              r_busy = 1'b0, g_busy = 1'b0, b_busy = 1'b0;
  logic              res_vld = 1'b0, res_busy;
  logic [23:0]       res_data = '0;
  logic              wr_vld, wr_busy = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  gau_frame_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start),
    .i_width(width), .i_height(height),
    .i_src_base(src_base), .i_dst_base(dst_base),
    .o_busy(busy), .o_done(done),
    .o_rd_vld(rd_vld), .o_rd_addr(rd_addr), .i_rd_busy(rd_busy), .i_rd_data(rd_data),
    .o_r_vld(r_vld), .o_g_vld(g_vld), .o_b_vld(b_vld),
    .o_r_data(r_data), .o_g_data(g_data), .o_b_data(b_data),
    .i_r_busy(r_busy), .i_g_busy(g_busy), .i_b_busy(b_busy),
    .i_result_vld(res_vld), .i_result_data(res_data), .o_result_busy(res_busy),
    .o_wr_vld(wr_vld), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_busy(wr_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_rd[$];
  logic [7:0]        exp_r[$], exp_g[$], exp_b[$];
  logic [ADDR_W-1:0] exp_wa[$];
  logic [23:0]       exp_wd[$];
  logic [23:0]       mem [1024];
  logic [23:0]       res_base = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: transfer 0x%0h with nothing expected", name, act);
  endtask

  // Memory model: data valid the cycle after an accepted request.
  always @(posedge clk)
    if (rd_vld && !rd_busy) rd_data <= mem[rd_addr[9:0]];

  // Filter model: after nine taps on every channel, offer res_base + pixel.
  int fr = 0, fg = 0, fb = 0, pix_idx = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      fr <= 0; fg <= 0; fb <= 0; pix_idx <= 0; res_vld <= 1'b0;
    end else begin
      if (r_vld && !r_busy) fr <= fr + 1;
      if (g_vld && !g_busy) fg <= fg + 1;
      if (b_vld && !b_busy) fb <= fb + 1;
      if (!res_vld && fr == 9 && fg == 9 && fb == 9) begin
        res_vld  <= 1'b1;
        res_data <= res_base + 24'(pix_idx);
      end
      if (res_vld && !res_busy) begin
        res_vld <= 1'b0; fr <= 0; fg <= 0; fb <= 0; pix_idx <= pix_idx + 1;
      end
    end
  end

  // Scoreboard monitors
  int rc = 0, gc = 0, bc = 0, wr_cnt = 0, done_cnt = 0;
  logic g_hold = 1'b0, wr_hold = 1'b0;
  logic [7:0] g_hold_data;
  logic [ADDR_W-1:0] wr_hold_addr;
  logic [23:0] wr_hold_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      rc = 0; gc = 0; bc = 0; wr_cnt = 0; done_cnt = 0; g_hold = 1'b0; wr_hold = 1'b0;
    end else begin
      if (rd_vld && !rd_busy) begin
        if (exp_rd.size() == 0) unexpected("rd_addr", 32'(rd_addr));
        else check("rd_addr", 32'(rd_addr), 32'(exp_rd.pop_front()));
      end
      if (r_vld && !r_busy) begin
        rc++;
        if (exp_r.size() == 0) unexpected("r_data", 32'(r_data));
        else check("r_data", 32'(r_data), 32'(exp_r.pop_front()));
      end
      if (g_vld && !g_busy) begin
        gc++;
        if (exp_g.size() == 0) unexpected("g_data", 32'(g_data));
        else check("g_data", 32'(g_data), 32'(exp_g.pop_front()));
      end
      if (b_vld && !b_busy) begin
        bc++;
        if (exp_b.size() == 0) unexpected("b_data", 32'(b_data));
        else check("b_data", 32'(b_data), 32'(exp_b.pop_front()));
      end
      if ((r_vld && !r_busy) || (g_vld && !g_busy) || (b_vld && !b_busy))
        check("chan_skew_ok", 32'((rc - gc <= 1) && (gc - rc <= 1) &&
                                  (rc - bc <= 1) && (bc - rc <= 1)), 32'd1);
      if (wr_vld && !wr_busy) begin
        wr_cnt++;
        if (exp_wa.size() == 0) unexpected("wr_addr", 32'(wr_addr));
        else begin
          check("wr_addr", 32'(wr_addr), 32'(exp_wa.pop_front()));
          check("wr_data", 32'(wr_data), 32'(exp_wd.pop_front()));
        end
      end
      if (g_hold) begin
        check("g_vld_held", 32'(g_vld), 32'd1);
        check("g_data_held", 32'(g_data), 32'(g_hold_data));
        check("r_idle_in_g_hold", 32'(r_vld), 32'd0);
      end
      if (wr_hold) begin
        check("wr_vld_held", 32'(wr_vld), 32'd1);
        check("wr_addr_held", 32'(wr_addr), 32'(wr_hold_addr));
        check("wr_data_held", 32'(wr_data), 32'(wr_hold_data));
        check("rd_in_wr_hold", 32'(rd_vld), 32'd0);
      end
      if (done) done_cnt++;
      g_hold = g_vld && g_busy;       g_hold_data = g_data;
      wr_hold = wr_vld && wr_busy;    wr_hold_addr = wr_addr; wr_hold_data = wr_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_vld"}, 32'(rd_vld), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_rgb_vld"}, 32'({r_vld, g_vld, b_vld}), 0);
    check({tag, "_rgb_data"}, 32'({b_data, g_data, r_data}), 0);
    check({tag, "_result_busy"}, 32'(res_busy), 1);
    check({tag, "_wr_vld"}, 32'(wr_vld), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
  endtask

  task automatic clear_expect();
    exp_rd.delete(); exp_r.delete(); exp_g.delete(); exp_b.delete();
    exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    rd_busy = 0; r_busy = 0; g_busy = 0; b_busy = 0; wr_busy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    clear_expect();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s: o_done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_drained(input string name, input int exp_wr);
    repeat (2) @(negedge clk);
    check({name, "_done_cnt"}, 32'(done_cnt), 1);
    check({name, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    check({name, "_rd_left"}, 32'(exp_rd.size()), 0);
    check({name, "_tap_left"}, 32'(exp_r.size() + exp_g.size() + exp_b.size()), 0);
    check({name, "_wr_left"}, 32'(exp_wa.size()), 0);
    check({name, "_busy_low"}, 32'(busy), 0);
  endtask

  // Reference: for every pixel and tap, what must be read, pushed and written.
  task automatic build_expect(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        for (int t = 0; t < 9; t++) begin
          int ny, nx;
          bit rd;
          logic [ADDR_W-1:0] a;
          logic [23:0] word;
          ny = y + t / 3 - 1;
          nx = x + t % 3 - 1;
`ifdef GAU_SEQ_EDGE_CLAMP_EN
          if (ny < 0) ny = 0;
          if (ny > h - 1) ny = h - 1;
          if (nx < 0) nx = 0;
          if (nx > w - 1) nx = w - 1;
          rd = 1;
`else
          rd = (ny >= 0) && (ny < h) && (nx >= 0) && (nx < w);
`endif
          word = '0;
          if (rd) begin
            a = ADDR_W'(int'(src_base) + ny * w + nx);
            exp_rd.push_back(a);
            word = mem[a[9:0]];
          end
          exp_r.push_back(word[7:0]);
          exp_g.push_back(word[15:8]);
          exp_b.push_back(word[23:16]);
        end
        exp_wa.push_back(ADDR_W'(int'(dst_base) + y * w + x));
        exp_wd.push_back(res_base + 24'(y * w + x));
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // 1x1 image, hand-computed vectors
    do_reset();
    mem[10'h100] = 24'h302010;
    width = 1; height = 1; src_base = 16'h0100; dst_base = 16'h0200;
    res_base = 24'hABCDEF;
`ifdef GAU_SEQ_EDGE_CLAMP_EN
    for (int t = 0; t < 9; t++) begin
      exp_rd.push_back(16'h0100);
      exp_r.push_back(8'h10); exp_g.push_back(8'h20); exp_b.push_back(8'h30);
    end
`else
    exp_rd.push_back(16'h0100);
    for (int t = 0; t < 9; t++) begin
      exp_r.push_back(t == 4 ? 8'h10 : 8'h00);
      exp_g.push_back(t == 4 ? 8'h20 : 8'h00);
      exp_b.push_back(t == 4 ? 8'h30 : 8'h00);
    end
`endif
    exp_wa.push_back(16'h0200); exp_wd.push_back(24'hABCDEF);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 32'(busy), 1);
    wait_done("one_by_one", 400);
    check_drained("one_by_one", 1);

    // 3x3, g backpressure on tap 0, write backpressure plus ignored start
    do_reset();
    for (int i = 0; i < 9; i++) mem[i] = 24'(i);
    width = 3; height = 3; src_base = 16'h0000; dst_base = 16'h0300;
    res_base = 24'h5A0000;
    build_expect(3, 3);
    g_busy = 1'b1; wr_busy = 1'b1;
    pulse_start();
    repeat (4) @(posedge clk);
    #1 g_busy = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (wr_vld) break;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start = 1'b1; width = 5; src_base = 16'h0040; end
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    wr_busy = 1'b0; width = 3; src_base = 16'h0000;
    wait_done("three_by_three", 2000);
    check_drained("three_by_three", 9);
    check("rgb_counts_equal", 32'((rc == 81) && (gc == 81) && (bc == 81)), 1);

    // Zero-width frame: done two cycles after start, no traffic
    do_reset();
    width = 0; height = 4;
    pulse_start();
    @(negedge clk);
    check("zero_done_early", 32'(done), 0);
    check("zero_busy", 32'(busy), 1);
    @(negedge clk);
    check("zero_done", 32'(done), 1);
    check("zero_busy_drop", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_no_traffic", 32'({rd_vld, r_vld, g_vld, b_vld, wr_vld, done}), 0);
    end
    check("zero_done_cnt", 32'(done_cnt), 1);

    // Reset during the push of pixel 2, then a clean rerun
    do_reset();
    width = 3; height = 3; src_base = 16'h0000; dst_base = 16'h0300;
    res_base = 24'h770000;
    build_expect(3, 3);
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (wr_cnt == 2 && r_vld) break;
    end
    check("mid_reached_pixel2", 32'(wr_cnt), 2);
    r_busy = 1'b1; g_busy = 1'b1; b_busy = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid");
    @(posedge clk); #1;
    rst_n = 1'b1; r_busy = 1'b0; g_busy = 1'b0; b_busy = 1'b0;
    clear_expect();
    build_expect(3, 3);
    pulse_start();
    wait_done("rerun", 2000);
    check_drained("rerun", 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
